// File: rtl/int_calc_mc.sv
// Multi-cycle unsigned integer calculator with valid/ready handshakes on both sides.
// One shared shift-add multiplier / restoring divider register serves MUL, DIV, MOD and POW.
module int_calc_mc #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       operation,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             sign,
  output logic             ovf,
  output logic             err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_SHL  = 3'd4;
  localparam logic [2:0] OP_LOG2 = 3'd5;
  localparam logic [2:0] OP_POW  = 3'd6;
  localparam logic [2:0] OP_MOD  = 3'd7;

  localparam int CW = $clog2(2 * WIDTH * WIDTH + 1);
  localparam int IW = $clog2(WIDTH);
  localparam logic [CW-1:0]    N_ITER = CW'(WIDTH);
  localparam logic [CW-1:0]    N_POW  = CW'(2 * WIDTH * WIDTH);
  localparam logic [IW-1:0]    IT_MAX = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] W_VEC  = WIDTH'(WIDTH);

  logic [1:0]         state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [CW-1:0]      cnt_q, cnt_d, n_q, n_d;
  logic [IW-1:0]      it_q, it_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   r_q, r_d, e_q, e_d;
  logic               sq_q, sq_d, povf_q, povf_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               sign_q, sign_d, ovf_q, ovf_d, err_q, err_d;

  logic [WIDTH:0]     mul_sum, div_shift, div_diff, add_full;
  logic [2*WIDTH-1:0] mul_next, div_next, shl_wide;
  logic               div_ok;
  logic [WIDTH-1:0]   pow_r_next, log2_val;

  // prod_q holds {high accumulator, multiplier} for MUL/POW and {remainder, quotient} for DIV/MOD
  assign mul_sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_next   = {mul_sum, prod_q[WIDTH-1:1]};
  assign div_shift  = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign div_diff   = div_shift - {1'b0, b_q};
  assign div_ok     = ~div_diff[WIDTH];
  assign div_next   = {div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0], prod_q[WIDTH-2:0], div_ok};
  assign add_full   = {1'b0, a_q} + {1'b0, b_q};
  assign shl_wide   = {{WIDTH{1'b0}}, a_q} << b_q;
  assign pow_r_next = e_q[WIDTH-1] ? mul_next[WIDTH-1:0] : r_q;

  always_comb begin
    log2_val = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (b_q[i]) log2_val = WIDTH'(i);
    end
  end

  always_comb begin
    state_d = state_q;  op_d = op_q;  a_d = a_q;  b_d = b_q;
    cnt_d = cnt_q;  n_d = n_q;  it_d = it_q;  prod_d = prod_q;  mcand_d = mcand_q;
    r_d = r_q;  e_d = e_q;  sq_d = sq_q;  povf_d = povf_q;
    res_d = res_q;  sign_d = sign_q;  ovf_d = ovf_q;  err_d = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          state_d = S_CALC;
          op_d = operation;  a_d = opa;  b_d = opb;
          cnt_d = '0;  it_d = '0;  n_d = '0;
          sign_d = 1'b0;  ovf_d = 1'b0;  err_d = 1'b0;
          case (operation)
            OP_MUL: begin
              n_d = N_ITER;  prod_d = {{WIDTH{1'b0}}, opb};  mcand_d = opa;
            end
            OP_DIV, OP_MOD: begin
              n_d = (opb == '0) ? '0 : N_ITER;  prod_d = {{WIDTH{1'b0}}, opa};
            end
            OP_POW: begin
              n_d = N_POW;  prod_d = {{WIDTH{1'b0}}, WIDTH'(1)};  mcand_d = WIDTH'(1);
              r_d = WIDTH'(1);  e_d = opb;  sq_d = 1'b1;  povf_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
      S_CALC: begin
        if (cnt_q == n_q) begin
          state_d = S_DONE;
          case (op_q)
            OP_ADD: {ovf_d, res_d} = add_full;
            OP_SUB: begin
              res_d = a_q - b_q;  sign_d = (a_q < b_q);
            end
            OP_MUL: begin
              res_d = prod_q[WIDTH-1:0];  ovf_d = |prod_q[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
              res_d = (b_q == '0) ? '1 : prod_q[WIDTH-1:0];  err_d = (b_q == '0);
            end
            OP_MOD: begin
              res_d = (b_q == '0) ? a_q : prod_q[2*WIDTH-1:WIDTH];  err_d = (b_q == '0);
            end
            OP_SHL: begin
              res_d = shl_wide[WIDTH-1:0];
              ovf_d = (|shl_wide[2*WIDTH-1:WIDTH]) | ((b_q >= W_VEC) & (|a_q));
            end
            OP_LOG2: begin
              res_d = log2_val;  err_d = (b_q == '0);
            end
            default: begin
              res_d = r_q;  ovf_d = povf_q;
            end
          endcase
        end else begin
          cnt_d = cnt_q + CW'(1);
          case (op_q)
            OP_MUL:         prod_d = mul_next;
            OP_DIV, OP_MOD: prod_d = div_next;
            OP_POW: begin
              prod_d = mul_next;
              it_d   = it_q + IW'(1);
              // Last bit of a multiply: commit it and preload the next one in the same cycle.
              // Overflow only counts for products that are actually kept.
              if (it_q == IT_MAX) begin
                it_d = '0;
                if (sq_q) begin
                  r_d     = mul_next[WIDTH-1:0];
                  povf_d  = povf_q | (|mul_next[2*WIDTH-1:WIDTH]);
                  prod_d  = {{WIDTH{1'b0}}, mul_next[WIDTH-1:0]};
                  mcand_d = a_q;
                  sq_d    = 1'b0;
                end else begin
                  r_d     = pow_r_next;
                  povf_d  = povf_q | (e_q[WIDTH-1] & (|mul_next[2*WIDTH-1:WIDTH]));
                  prod_d  = {{WIDTH{1'b0}}, pow_r_next};
                  mcand_d = pow_r_next;
                  e_d     = e_q << 1;
                  sq_d    = 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;  op_q <= '0;  a_q <= '0;  b_q <= '0;
      cnt_q <= '0;  n_q <= '0;  it_q <= '0;  prod_q <= '0;  mcand_q <= '0;
      r_q <= '0;  e_q <= '0;  sq_q <= 1'b0;  povf_q <= 1'b0;
      res_q <= '0;  sign_q <= 1'b0;  ovf_q <= 1'b0;  err_q <= 1'b0;
    end else begin
      state_q <= state_d;  op_q <= op_d;  a_q <= a_d;  b_q <= b_d;
      cnt_q <= cnt_d;  n_q <= n_d;  it_q <= it_d;  prod_q <= prod_d;  mcand_q <= mcand_d;
      r_q <= r_d;  e_q <= e_d;  sq_q <= sq_d;  povf_q <= povf_d;
      res_q <= res_d;  sign_q <= sign_d;  ovf_q <= ovf_d;  err_q <= err_d;
    end
  end

  assign in_ready  = rst & (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = res_q;
  assign sign      = sign_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule
